// File: rtl/srx_pkg.sv
// Shared types and constants for the sequential right shifter.
// SRX_FAST_STEP_EN (macro) selects the 4-bit-per-edge step in srx_seq_shifter.
package srx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } srx_state_t;

  // Positions covered by one fast-path step.
  localparam int SRX_STEP = 4;

  // Fill bit shifted in from the top: sign for SRA, zero for SRL.
  function automatic logic sel_fill(input logic arith, input logic msb);
    return arith & msb;
  endfunction

endpackage

// File: rtl/srl_step.sv
// Combinational right shift by one position with an explicit fill bit.
module srl_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] din,
  input  logic         fill,
  output logic [N-1:0] dout
);

  assign dout = {fill, din[N-1:1]};

endmodule

// File: rtl/srx_seq_shifter.sv
// Sequential SRL/SRA shifter with a start/busy/done handshake.
// Shifts one position per clock; with SRX_FAST_STEP_EN defined it shifts
// four positions per clock while at least four remain, then single steps.
module srx_seq_shifter
  import srx_pkg::*;
#(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [N-1:0]       result,
  output logic               busy,
  output logic               done
);

  srx_state_t         state;
  logic [SHAMT_W-1:0] cnt;
  logic               fill;
  logic [N-1:0]       nxt_result;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] cnt_nxt;

`ifdef SRX_FAST_STEP_EN
  logic [N-1:0] stage [0:SRX_STEP];
  logic         step_big;

  assign stage[0] = result;

  // Four single-bit stages in series give the 4-position fast step.
  for (genvar i = 0; i < SRX_STEP; i++) begin : g_step
    srl_step #(.N(N)) u_step (
      .din  (stage[i]),
      .fill (fill),
      .dout (stage[i+1])
    );
  end

  // Take the wide step only while it cannot overshoot the remaining count.
  always_comb begin
    step_big   = ({1'b0, cnt} >= (SHAMT_W+1)'(SRX_STEP));
    nxt_result = step_big ? stage[SRX_STEP] : stage[1];
    step_amt   = step_big ? SHAMT_W'(SRX_STEP) : SHAMT_W'(1);
  end
`else
  logic [N-1:0] stage1;

  srl_step #(.N(N)) u_step (
    .din  (result),
    .fill (fill),
    .dout (stage1)
  );

  // One position per edge.
  always_comb begin
    nxt_result = stage1;
    step_amt   = SHAMT_W'(1);
  end
`endif

  assign cnt_nxt = cnt - step_amt;

  // Control FSM with registered result, busy and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            result <= a;
            cnt    <= shamt;
            fill   <= sel_fill(arith, a[N-1]);
            if (shamt != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          result <= nxt_result;
          cnt    <= cnt_nxt;
          if (cnt_nxt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srx_seq_shifter.sv
// Scoreboard bench for srx_seq_shifter: driver pushes expected results and
// completion cycles, a negedge monitor pops and compares on each done pulse.
module tb_srx_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t q[$];

  srx_seq_shifter #(.N(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .shamt  (shamt),
    .arith  (arith),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] av, input int sh, input logic ar);
    logic signed [31:0] s;
    s = av;
    if (ar) return 32'(s >>> sh);
    return av >> sh;
  endfunction

  function automatic int lat_of(input int sh);
`ifdef SRX_FAST_STEP_EN
    return sh / 4 + sh % 4;
`else
    return sh;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = q.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
          chk("busy_in_done", 64'(busy), 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail_now("idle_timeout");
  endtask

  task automatic issue(input logic [31:0] av, input int sh, input logic ar, input bit b2b);
    exp_t e;
    int n;
    if (b2b) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 200);
      if (!done) fail_now("b2b_done_timeout");
    end else begin
      wait_idle();
      @(negedge clk);
    end
    start = 1'b1;
    a     = av;
    shamt = 5'(sh);
    arith = ar;
    @(posedge clk);
    #1;
    e.res = model(av, sh, ar);
    e.lat = lat_of(sh);
    e.cyc = cyc + e.lat;
    q.push_back(e);
    start = 1'b0;
    a     = $urandom;
    shamt = 5'($urandom);
    arith = 1'($urandom);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    shamt = '0;
    arith = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Directed cases.
    issue(32'h8000_0000, 31, 1'b0, 1'b0);
    issue(32'h8000_0000, 4, 1'b1, 1'b0);
    issue(32'h7000_0000, 4, 1'b1, 1'b0);
    issue(32'h1234_5678, 0, 1'b0, 1'b0);
    issue(32'h8000_0000, 31, 1'b1, 1'b0);
    issue(32'hDEAD_BEEF, 9, 1'b1, 1'b0);

    // Start pulsed mid-SHIFT is ignored, then back-to-back issue through DONE.
    issue(32'hC0FF_EE00, 12, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 32'h0000_FFFF;
    shamt = 5'd2;
    arith = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    issue(32'h0F0F_1234, 7, 1'b0, 1'b1);
    issue(32'h8765_4321, 0, 1'b1, 1'b1);
    issue(32'h8765_4321, 3, 1'b1, 1'b1);

    // Reset three edges into a shamt=10 operation.
    issue(32'hA5A5_A5A5, 10, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    q.delete();
    busy_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // Randomized operations, some issued back-to-back.
    for (int i = 0; i < 60; i++) begin
      issue($urandom, int'($urandom_range(0, 31)), 1'($urandom), bit'($urandom_range(0, 2) == 0));
    end

    wait_idle();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
